// File: rtl/game_pkg.sv
// Shared definitions for the digit-entry game blocks: state encoding and digit geometry.
// Reused by the generator and checker blocks as well as digit_entry.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } entry_state_t;

  localparam int NUM_DIGITS    = 4;
  localparam int DIGIT_W       = 4;
  localparam int MAX_DIGIT_DEF = 8;
  localparam int ENTRY_W       = NUM_DIGITS * DIGIT_W;
  localparam int COUNT_W       = 3;

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter for digit_entry; only instantiated when DIGIT_ENTRY_TIMEOUT_EN is defined.
// expired flags the idle cycle on which the LIMIT-th consecutive idle cycle in ENTRY completes.
module entry_timer #(
  parameter int LIMIT = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  // Counter rests at zero outside ENTRY, so entering ENTRY always starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/digit_entry.sv
// Four-digit entry FSM (IDLE/ENTRY/DONE) with digit rejection and backspace; all outputs registered.
// Optional inactivity timeout is enabled by defining DIGIT_ENTRY_TIMEOUT_EN.
import game_pkg::*;

module digit_entry #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int MAX_DIGIT      = MAX_DIGIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 digit_valid,
  input  logic [DIGIT_W-1:0]   digit,
  input  logic                 backspace,
  output logic [ENTRY_W-1:0]   userInt,
  output logic [COUNT_W-1:0]   count,
  output logic                 entry_active,
  output logic                 entry_done,
  output logic                 bad_digit,
  output logic                 timed_out
);

  localparam logic [DIGIT_W-1:0] MAX_V  = DIGIT_W'(MAX_DIGIT);
  localparam logic [COUNT_W-1:0] LAST_C = COUNT_W'(NUM_DIGITS - 1);

  entry_state_t state;
  logic         timeout_hit;

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  entry_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state == ENTRY),
    .clear  (start | digit_valid | backspace),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timed_out <= 1'b0;
    end else if (start) begin
      timed_out <= 1'b0;
    end else if (timeout_hit) begin
      timed_out <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // Priority inside ENTRY: start, then timeout, then backspace (which swallows a same-cycle digit).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      userInt      <= '0;
      count        <= '0;
      entry_active <= 1'b0;
      entry_done   <= 1'b0;
      bad_digit    <= 1'b0;
    end else begin
      bad_digit <= 1'b0;
      if (start) begin
        state        <= ENTRY;
        userInt      <= '0;
        count        <= '0;
        entry_active <= 1'b1;
        entry_done   <= 1'b0;
      end else if (state == ENTRY) begin
        if (timeout_hit) begin
          state        <= DONE;
          entry_active <= 1'b0;
          entry_done   <= 1'b1;
        end else if (backspace) begin
          if (count != '0) begin
            userInt <= {{DIGIT_W{1'b0}}, userInt[ENTRY_W-1:DIGIT_W]};
            count   <= count - 1'b1;
          end
        end else if (digit_valid) begin
          if (digit > MAX_V) begin
            bad_digit <= 1'b1;
          end else begin
            userInt <= {userInt[ENTRY_W-DIGIT_W-1:0], digit};
            count   <= count + 1'b1;
            if (count == LAST_C) begin
              state        <= DONE;
              entry_active <= 1'b0;
              entry_done   <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: table-driven vectors through a scoreboard queue,
// plus hand-written reset and (with DIGIT_ENTRY_TIMEOUT_EN) timeout sequences.
module tb_digit_entry;

  typedef struct packed {
    logic [15:0] u;
    logic [2:0]  c;
    logic        act;
    logic        done;
    logic        bad;
    logic        to;
  } exp_t;

  typedef struct {
    logic       st;
    logic       dv;
    logic [3:0] dg;
    logic       bs;
    exp_t       e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        backspace;
  logic [15:0] userInt;
  logic [2:0]  count;
  logic        entry_active;
  logic        entry_done;
  logic        bad_digit;
  logic        timed_out;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[26];

  digit_entry #(
    .TIMEOUT_CYCLES(10),
    .MAX_DIGIT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .backspace   (backspace),
    .userInt     (userInt),
    .count       (count),
    .entry_active(entry_active),
    .entry_done  (entry_done),
    .bad_digit   (bad_digit),
    .timed_out   (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_exp(logic [15:0] u, logic [2:0] c, logic act, logic done,
                                  logic bad, logic to);
    exp_t e;
    e.u = u; e.c = c; e.act = act; e.done = done; e.bad = bad; e.to = to;
    return e;
  endfunction

  function automatic vec_t mk(logic st, logic dv, logic [3:0] dg, logic bs, logic [15:0] u,
                              logic [2:0] c, logic act, logic done, logic bad);
    vec_t v;
    v.st = st; v.dv = dv; v.dg = dg; v.bs = bs;
    v.e  = mk_exp(u, c, act, done, bad, 1'b0);
    return v;
  endfunction

  task automatic check_output(input string name);
    exp_t e;
    exp_t a;
    checks++;
    a = {userInt, count, entry_active, entry_done, bad_digit, timed_out};
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, actual=%h", name, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL %s: actual user=%h cnt=%0d act=%b done=%b bad=%b to=%b required user=%h cnt=%0d act=%b done=%b bad=%b to=%b",
                 name, a.u, a.c, a.act, a.done, a.bad, a.to,
                 e.u, e.c, e.act, e.done, e.bad, e.to);
      end
    end
  endtask

  // Drives one cycle of inputs, queues the expectation, and checks just after the edge.
  task automatic apply_stimulus(input logic st, input logic dv, input logic [3:0] dg,
                                input logic bs, input exp_t e, input string name);
    start       = st;
    digit_valid = dv;
    digit       = dg;
    backspace   = bs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output(name);
  endtask

  initial begin
    // start, digit_valid, digit, backspace, userInt, count, active, done, bad
    vecs[0]  = mk(0, 0, 4'd0, 0, 16'h0000, 3'd0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 4'd3, 0, 16'h0003, 3'd1, 1, 0, 0);
    vecs[3]  = mk(0, 1, 4'd1, 0, 16'h0031, 3'd2, 1, 0, 0);
    vecs[4]  = mk(0, 1, 4'd4, 0, 16'h0314, 3'd3, 1, 0, 0);
    vecs[5]  = mk(0, 1, 4'd1, 0, 16'h3141, 3'd4, 0, 1, 0);
    vecs[6]  = mk(0, 1, 4'd7, 0, 16'h3141, 3'd4, 0, 1, 0);
    vecs[7]  = mk(0, 0, 4'd0, 1, 16'h3141, 3'd4, 0, 1, 0);
    vecs[8]  = mk(0, 1, 4'd9, 1, 16'h3141, 3'd4, 0, 1, 0);
    vecs[9]  = mk(1, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 0, 0);
    vecs[10] = mk(0, 1, 4'd2, 0, 16'h0002, 3'd1, 1, 0, 0);
    vecs[11] = mk(0, 1, 4'd9, 0, 16'h0002, 3'd1, 1, 0, 1);
    vecs[12] = mk(0, 1, 4'd5, 0, 16'h0025, 3'd2, 1, 0, 0);
    vecs[13] = mk(0, 0, 4'd0, 1, 16'h0002, 3'd1, 1, 0, 0);
    vecs[14] = mk(0, 1, 4'd7, 0, 16'h0027, 3'd2, 1, 0, 0);
    vecs[15] = mk(0, 1, 4'd0, 0, 16'h0270, 3'd3, 1, 0, 0);
    vecs[16] = mk(0, 1, 4'd8, 0, 16'h2708, 3'd4, 0, 1, 0);
    vecs[17] = mk(1, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 0, 0);
    vecs[18] = mk(0, 1, 4'd6, 0, 16'h0006, 3'd1, 1, 0, 0);
    vecs[19] = mk(0, 1, 4'd2, 0, 16'h0062, 3'd2, 1, 0, 0);
    vecs[20] = mk(0, 1, 4'd6, 1, 16'h0006, 3'd1, 1, 0, 0);
    vecs[21] = mk(1, 1, 4'd5, 0, 16'h0000, 3'd0, 1, 0, 0);
    vecs[22] = mk(0, 0, 4'd0, 1, 16'h0000, 3'd0, 1, 0, 0);
    vecs[23] = mk(0, 1, 4'd9, 1, 16'h0000, 3'd0, 1, 0, 0);
    vecs[24] = mk(0, 1, 4'd1, 0, 16'h0001, 3'd1, 1, 0, 0);
    vecs[25] = mk(0, 1, 4'hF, 0, 16'h0001, 3'd1, 1, 0, 1);

    rst         = 1'b0;
    start       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    backspace   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk_exp(16'h0000, 3'd0, 0, 0, 0, 0));
    check_output("reset_state");
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].st, vecs[i].dv, vecs[i].dg, vecs[i].bs, vecs[i].e,
                     $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-entry, then digits ignored until start.
    apply_stimulus(1, 0, 4'd0, 0, mk_exp(16'h0000, 3'd0, 1, 0, 0, 0), "rs_start");
    apply_stimulus(0, 1, 4'd3, 0, mk_exp(16'h0003, 3'd1, 1, 0, 0, 0), "rs_d3");
    apply_stimulus(0, 1, 4'd1, 0, mk_exp(16'h0031, 3'd2, 1, 0, 0, 0), "rs_d1");
    start       = 1'b0;
    digit_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    sb.push_back(mk_exp(16'h0000, 3'd0, 0, 0, 0, 0));
    check_output("rs_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_stimulus(0, 1, 4'd4, 0, mk_exp(16'h0000, 3'd0, 0, 0, 0, 0), "rs_ign_digit");
    apply_stimulus(0, 0, 4'd0, 1, mk_exp(16'h0000, 3'd0, 0, 0, 0, 0), "rs_ign_bs");
    apply_stimulus(0, 1, 4'd9, 0, mk_exp(16'h0000, 3'd0, 0, 0, 0, 0), "rs_ign_bad");
    apply_stimulus(1, 0, 4'd0, 0, mk_exp(16'h0000, 3'd0, 1, 0, 0, 0), "rs_restart");
    apply_stimulus(0, 1, 4'd2, 0, mk_exp(16'h0002, 3'd1, 1, 0, 0, 0), "rs_d2");

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    apply_stimulus(1, 0, 4'd0, 0, mk_exp(16'h0000, 3'd0, 1, 0, 0, 0), "to_start");
    apply_stimulus(0, 1, 4'd5, 0, mk_exp(16'h0005, 3'd1, 1, 0, 0, 0), "to_d5");
    for (int k = 1; k < 10; k++) begin
      apply_stimulus(0, 0, 4'd0, 0, mk_exp(16'h0005, 3'd1, 1, 0, 0, 0),
                     $sformatf("to_idle%0d", k));
    end
    apply_stimulus(0, 0, 4'd0, 0, mk_exp(16'h0005, 3'd1, 0, 1, 0, 1), "to_expire");
    apply_stimulus(0, 1, 4'd3, 0, mk_exp(16'h0005, 3'd1, 0, 1, 0, 1), "to_hold");
    apply_stimulus(1, 0, 4'd0, 0, mk_exp(16'h0000, 3'd0, 1, 0, 0, 0), "to_clear");
`else
    repeat (12) apply_stimulus(0, 0, 4'd0, 0, mk_exp(16'h0002, 3'd1, 1, 0, 0, 0), "no_timeout");
`endif

    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drain: actual=%0d required=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000000, SHALL set the inactivity limit in clk cycles (used only with the timeout feature).
REQ-002 Parameter MAX_DIGIT, default 8, SHALL set the largest accepted digit value (the game digit range is 0..8).
REQ-003 Ports SHALL be exactly:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a new 4-digit entry
digit_valid  input  1  one-cycle pulse; digit is valid this cycle
digit  input  4  entered digit value
backspace  input  1  one-cycle pulse; removes the last entered digit
userInt  output  16  assembled entry, 4 bits per digit
count  output  3  number of digits held, 0..4
entry_active  output  1  high while in ENTRY
entry_done  output  1  high while in DONE
bad_digit  output  1  one-cycle pulse on a rejected digit
timed_out  output  1  high in DONE if DONE was reached by timeout

Function
REQ-004 The block SHALL implement states IDLE, ENTRY and DONE.
REQ-005 start SHALL move the block from any state to ENTRY on the next edge, clearing userInt, count and timed_out.
REQ-006 In ENTRY, a digit_valid with digit<=MAX_DIGIT SHALL be accepted: userInt <= {userInt[11:0],digit} and count increments, both visible the next cycle.
REQ-007 In ENTRY, a digit_valid with digit>MAX_DIGIT SHALL leave userInt and count unchanged and SHALL pulse bad_digit for exactly one cycle.
REQ-008 The fourth accepted digit SHALL move the state to ENTRY->DONE on the same edge; entry_done SHALL be high from the next cycle with userInt = digits in entry order, first digit in [15:12].
REQ-009 In ENTRY with count>0, backspace SHALL apply userInt <= {4'h0,userInt[15:4]} and decrement count; with count=0 it SHALL be ignored.
REQ-010 When backspace and digit_valid occur in the same cycle, backspace SHALL be applied and the digit SHALL be dropped, with no bad_digit pulse.
REQ-011 When start occurs in the same cycle as digit_valid or backspace, start SHALL win and the other input SHALL be dropped.
REQ-012 In IDLE and DONE, digit_valid and backspace SHALL be ignored, with no bad_digit pulse.
REQ-013 In DONE, userInt and count SHALL hold until the next start or reset.
REQ-014 All outputs SHALL be registered; no combinational path SHALL exist from an input to an output.

Reset
REQ-015 On rst low, the block SHALL asynchronously enter IDLE with userInt=0, count=0, entry_active=0, entry_done=0, bad_digit=0 and timed_out=0.
REQ-016 A reset asserted mid-entry SHALL discard the partial entry; after release the block SHALL remain in IDLE until start.

Configuration
REQ-017 With macro DIGIT_ENTRY_TIMEOUT_EN defined, an inactivity counter SHALL clear on entry to ENTRY and on each start, digit_valid or backspace pulse; when it reaches TIMEOUT_CYCLES in ENTRY, the state SHALL move to DONE with timed_out=1 and the partial userInt held.
REQ-018 Without DIGIT_ENTRY_TIMEOUT_EN, the counter logic SHALL be absent, timed_out SHALL be tied to 0, and ENTRY SHALL persist indefinitely.

Structure
REQ-019 A shared package game_pkg SHALL hold the state enum (IDLE, ENTRY, DONE), NUM_DIGITS=4, DIGIT_W=4 and MAX_DIGIT_DEF=8, for reuse by the generator and checker blocks.
REQ-020 The inactivity counter SHALL be a sub-module named entry_timer, instantiated only under DIGIT_ENTRY_TIMEOUT_EN.

Verification
REQ-021 Entry: start, then digits 3,1,4,1 -> userInt=16'h3141, count=4, entry_done=1 one cycle after the last digit.
REQ-022 Rejection and backspace: start, then 2, 9, 5, backspace, 7, 0, 8 -> one bad_digit pulse on the 9, final userInt=16'h2708.
REQ-023 Collision: digit_valid=6 and backspace in the same cycle at count=2 -> count=1, no 6 stored; start with digit_valid in the same cycle -> count=0.
REQ-024 Reset: rst low after 2 digits -> all outputs 0 asynchronously; digits after release are ignored until start.
REQ-025 Timeout (macro on, TIMEOUT_CYCLES=10): start, digit 5, then 10 idle cycles -> entry_done=1, timed_out=1, userInt=16'h0005, count=1.
REQ-026 Ignore in DONE: after a completed entry, digit_valid=1 and backspace -> userInt and count unchanged, no bad_digit pulse.
